// File: rtl/monitor_pkg.sv
// Shared types for the commit monitor: halt FSM states, repeat counter and
// lane PC arrays (lanes are zero-extended into the widest supported PC word).
package monitor_pkg;

  localparam int unsigned MAX_LANES = 4;
  localparam int unsigned MAX_XLEN  = 64;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ARMED  = 2'd1,
    HALTED = 2'd2
  } mon_state_e;

  typedef logic [3:0]          rep_cnt_t;
  typedef logic [MAX_XLEN-1:0] pc_word_t;
  typedef pc_word_t [MAX_LANES-1:0] pc_lanes_t;

  function automatic rep_cnt_t rep_inc(input rep_cnt_t c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

endpackage

// File: rtl/lane_prefix_count.sv
// Exclusive prefix count and total popcount of the accepted commit lanes.
module lane_prefix_count
  import monitor_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input  logic [LANES-1:0]            acc_i,
  output logic [LANES-1:0][CNT_W-1:0] prefix_o,
  output logic [CNT_W-1:0]            count_o
);

  logic [CNT_W-1:0] run_sum;

  always_comb begin
    run_sum  = '0;
    prefix_o = '0;
    for (int i = 0; i < LANES; i++) begin
      prefix_o[i] = run_sum;
      run_sum     = run_sum + CNT_W'(acc_i[i]);
    end
    count_o = run_sum;
  end

endmodule

// File: rtl/commit_monitor.sv
// Commit monitor: numbers retiring instructions per lane and detects a
// program parked in a self-loop, raising a sticky halt.
//
// state  | meaning
// RUN    | normal counting, watching for repeated self-loops
// ARMED  | repeat threshold met, delay counter running toward halt
// HALTED | loop confirmed; inputs ignored until reset
module commit_monitor
  import monitor_pkg::*;
#(
  parameter int unsigned LANES       = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ORDER_W     = 64,
  parameter int unsigned HALT_REPEAT = 2,
  parameter int unsigned HALT_DELAY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic [LANES-1:0]         valid_i,
  input  logic [LANES*XLEN-1:0]    pc_rdata_i,
  input  logic [LANES*XLEN-1:0]    pc_wdata_i,
  output logic [LANES-1:0]         commit_o,
  output logic [LANES*ORDER_W-1:0] order_o,
  output logic [ORDER_W-1:0]       retired_o,
  output logic                     halt_o
);

  mon_state_e                      state_q, state_d;
  logic [LANES-1:0]                commit_q, commit_d;
  logic [LANES-1:0][ORDER_W-1:0]   order_q, order_d;
  logic [ORDER_W-1:0]              retired_q, retired_d;
  pc_word_t                        loop_pc_q, loop_pc_d;
  rep_cnt_t                        rep_q, rep_d;
  logic [3:0]                      dly_q, dly_d;

  logic [LANES-1:0]                acc;
  logic [MAX_LANES-1:0]            acc_ext;
  logic [LANES-1:0][CNT_W-1:0]     prefix;
  logic [CNT_W-1:0]                count;
  pc_lanes_t                       pc_r, pc_w;
  logic                            judged_vld;
  pc_word_t                        judged_r, judged_w;
  logic                            self_loop, non_loop;

  assign acc     = (stall_i || state_q == HALTED) ? '0 : valid_i;
  assign acc_ext = MAX_LANES'(acc);

  lane_prefix_count #(.LANES(LANES)) u_prefix (
    .acc_i    (acc),
    .prefix_o (prefix),
    .count_o  (count)
  );

  always_comb begin
    pc_r = '0;
    pc_w = '0;
    for (int i = 0; i < LANES; i++) begin
      pc_r[i] = MAX_XLEN'(pc_rdata_i[i*XLEN +: XLEN]);
      pc_w[i] = MAX_XLEN'(pc_wdata_i[i*XLEN +: XLEN]);
    end
  end

  // Only the youngest accepted lane decides whether this cycle looped.
  always_comb begin
    judged_vld = 1'b0;
    judged_r   = '0;
    judged_w   = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (acc_ext[i]) begin
        judged_vld = 1'b1;
        judged_r   = pc_r[i];
        judged_w   = pc_w[i];
      end
    end
    self_loop = judged_vld && (judged_r == judged_w);
    non_loop  = judged_vld && (judged_r != judged_w);
  end

  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    loop_pc_d = loop_pc_q;
    dly_d     = dly_q;
    commit_d  = acc;
    retired_d = retired_q + ORDER_W'(count);
    for (int i = 0; i < LANES; i++) begin
      order_d[i] = retired_q + ORDER_W'(prefix[i]);
    end

    if (self_loop) begin
      if (judged_r == loop_pc_q) begin
        rep_d = rep_inc(rep_q);
      end else begin
        loop_pc_d = judged_r;
        rep_d     = 4'd1;
      end
    end else if (non_loop) begin
      rep_d = '0;
    end

    // Arming uses the registered count, so a non-loop in the same cycle wins.
    case (state_q)
      RUN: begin
        if (rep_q >= 4'(HALT_REPEAT) && !non_loop) begin
          if (HALT_DELAY == 0) begin
            state_d = HALTED;
          end else begin
            state_d = ARMED;
            dly_d   = 4'(HALT_DELAY);
          end
        end
      end
      ARMED: begin
        if (non_loop) begin
          state_d = RUN;
          dly_d   = '0;
        end else if (dly_q <= 4'd1) begin
          state_d = HALTED;
          dly_d   = '0;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      commit_q  <= '0;
      order_q   <= '0;
      retired_q <= '0;
      loop_pc_q <= '0;
      rep_q     <= '0;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      commit_q  <= commit_d;
      order_q   <= order_d;
      retired_q <= retired_d;
      loop_pc_q <= loop_pc_d;
      rep_q     <= rep_d;
      dly_q     <= dly_d;
    end
  end

  assign commit_o  = commit_q;
  assign order_o   = order_q;
  assign retired_o = retired_q;
  assign halt_o    = (state_q == HALTED);

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor (LANES=2, HALT_REPEAT=2, HALT_DELAY=1): directed
// scenarios plus random traffic against a timestamp-based reference model.
module tb_commit_monitor;

  localparam int HR = 2;
  localparam int HD = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall_i;
  logic [1:0]   valid_i;
  logic [63:0]  pc_rdata_i;
  logic [63:0]  pc_wdata_i;
  logic [1:0]   commit_o;
  logic [127:0] order_o;
  logic [63:0]  retired_o;
  logic         halt_o;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [63:0] m_ret;
  logic [63:0] m_ord [2];
  logic [1:0]  m_commit;
  logic [31:0] m_lpc;
  int          m_rep;
  bit          m_halt;
  bit          m_pend;
  int          m_halt_edge;
  int          m_edge;

  commit_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .valid_i    (valid_i),
    .pc_rdata_i (pc_rdata_i),
    .pc_wdata_i (pc_wdata_i),
    .commit_o   (commit_o),
    .order_o    (order_o),
    .retired_o  (retired_o),
    .halt_o     (halt_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] v, input logic s,
                       input logic [31:0] r0, input logic [31:0] w0,
                       input logic [31:0] r1, input logic [31:0] w1);
    valid_i    = v;
    stall_i    = s;
    pc_rdata_i = {r1, r0};
    pc_wdata_i = {w1, w0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive(2'b00, 1'b0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
  endtask

  task automatic model_reset();
    m_ret    = '0;
    m_ord[0] = '0;
    m_ord[1] = '0;
    m_commit = '0;
    m_lpc    = '0;
    m_rep    = 0;
    m_halt   = 0;
    m_pend   = 0;
    m_edge   = 0;
  endtask

  // One clock edge of the spec-level behaviour for the given inputs.
  task automatic model_edge(input logic [1:0] v, input logic s,
                            input logic [31:0] r0, input logic [31:0] w0,
                            input logic [31:0] r1, input logic [31:0] w1);
    logic [31:0] rr [2];
    logic [31:0] ww [2];
    logic [31:0] jr, jw;
    bit jv, nonloop;
    int n, old_rep;
    rr[0] = r0; rr[1] = r1; ww[0] = w0; ww[1] = w1;
    m_edge++;
    if (m_halt) begin
      m_commit = 2'b00;
      return;
    end
    n = 0; jv = 0; jr = '0; jw = '0;
    for (int i = 0; i < 2; i++) begin
      if (v[i] && !s) begin
        m_commit[i] = 1'b1;
        m_ord[i] = m_ret + 64'(n);
        n++;
        jv = 1; jr = rr[i]; jw = ww[i];
      end else begin
        m_commit[i] = 1'b0;
      end
    end
    nonloop = jv && (jr != jw);
    old_rep = m_rep;
    if (jv && jr == jw) begin
      if (jr == m_lpc) m_rep = (m_rep < 15) ? m_rep + 1 : 15;
      else begin m_lpc = jr; m_rep = 1; end
    end else if (nonloop) begin
      m_rep = 0;
    end
    if (m_pend) begin
      if (nonloop) m_pend = 0;
      else if (m_edge >= m_halt_edge) begin m_halt = 1; m_pend = 0; end
    end else if (old_rep >= HR && !nonloop) begin
      if (HD == 0) m_halt = 1;
      else begin m_pend = 1; m_halt_edge = m_edge + HD; end
    end
    m_ret = m_ret + 64'(n);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(2'b11, 1'b0, 32'h10, 32'h14, 32'h14, 32'h18);
    #2;
    total++;
    if (commit_o !== 2'b00 || order_o !== '0) begin
      bad++; $display("FAIL reset_outputs commit=%b order=%h want 0", commit_o, order_o);
    end
    tick();
    total++;
    if (retired_o !== 64'd0 || halt_o !== 1'b0 || commit_o !== 2'b00) begin
      bad++; $display("FAIL reset_hold retired=%0d halt=%b commit=%b want 0", retired_o, halt_o, commit_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_full_width();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 1'b0, 32'h1000 + 32'(8*k), 32'h1004 + 32'(8*k),
            32'h1004 + 32'(8*k), 32'h1008 + 32'(8*k));
      tick();
      total++;
      if (commit_o !== 2'b11 || order_o[63:0] !== 64'(2*k) || order_o[127:64] !== 64'(2*k+1)) begin
        bad++; $display("FAIL full_width_%0d commit=%b ord0=%0d ord1=%0d want 11 %0d %0d",
                        k, commit_o, order_o[63:0], order_o[127:64], 2*k, 2*k+1);
      end
    end
    drive(2'b00, 1'b0, 0, 0, 0, 0);
    tick();
    total++;
    if (retired_o !== 64'd6 || commit_o !== 2'b00) begin
      bad++; $display("FAIL full_width_retired retired=%0d commit=%b want 6 00", retired_o, commit_o);
    end
  endtask

  task automatic test_sparse();
    apply_reset();
    drive(2'b10, 1'b0, 32'h1, 32'h1, 32'h200, 32'h204);
    tick();
    total++;
    if (commit_o !== 2'b10 || order_o[127:64] !== 64'd0) begin
      bad++; $display("FAIL sparse_hi commit=%b ord1=%0d want 10 0", commit_o, order_o[127:64]);
    end
    drive(2'b01, 1'b0, 32'h204, 32'h208, 32'h7, 32'h7);
    tick();
    total++;
    if (commit_o !== 2'b01 || order_o[63:0] !== 64'd1) begin
      bad++; $display("FAIL sparse_lo commit=%b ord0=%0d want 01 1", commit_o, order_o[63:0]);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    drive(2'b11, 1'b0, 32'h300, 32'h304, 32'h304, 32'h308);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 1'b1, 32'h308, 32'h308, 32'h308, 32'h308);
      tick();
      total++;
      if (commit_o !== 2'b00 || retired_o !== 64'd2) begin
        bad++; $display("FAIL stall_%0d commit=%b retired=%0d want 00 2", k, commit_o, retired_o);
      end
    end
    // stalled self-loops must not have advanced loop detection
    drive(2'b01, 1'b0, 32'h308, 32'h308, 0, 0);
    tick();
    drive(2'b00, 1'b0, 0, 0, 0, 0);
    repeat (3) tick();
    total++;
    if (halt_o !== 1'b0 || retired_o !== 64'd3) begin
      bad++; $display("FAIL stall_no_loop halt=%b retired=%0d want 0 3", halt_o, retired_o);
    end
  endtask

  task automatic test_loop_switch();
    apply_reset();
    drive(2'b01, 1'b0, 32'h100, 32'h100, 0, 0);
    tick();
    drive(2'b01, 1'b0, 32'h104, 32'h104, 0, 0);
    tick();
    drive(2'b00, 1'b0, 0, 0, 0, 0);
    repeat (4) tick();
    total++;
    if (halt_o !== 1'b0) begin
      bad++; $display("FAIL loop_switch_nohalt halt=%b want 0", halt_o);
    end
    drive(2'b01, 1'b0, 32'h104, 32'h108, 0, 0);
    tick();
    drive(2'b01, 1'b0, 32'h104, 32'h104, 0, 0);
    tick();
    drive(2'b00, 1'b0, 0, 0, 0, 0);
    repeat (4) tick();
    total++;
    if (halt_o !== 1'b0) begin
      bad++; $display("FAIL loop_cleared halt=%b want 0", halt_o);
    end
    drive(2'b01, 1'b0, 32'h104, 32'h104, 0, 0);
    tick();
    drive(2'b00, 1'b0, 0, 0, 0, 0);
    repeat (2) tick();
    total++;
    if (halt_o !== 1'b1) begin
      bad++; $display("FAIL loop_resume_halt halt=%b want 1", halt_o);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    // lane 0 is not a loop; lane 1 (youngest) is, and alone decides
    drive(2'b11, 1'b0, 32'h80000030, 32'h80000034, 32'h80000040, 32'h80000040);
    tick();
    tick();
    total++;
    if (halt_o !== 1'b0 || retired_o !== 64'd4) begin
      bad++; $display("FAIL halt_second_accept halt=%b retired=%0d want 0 4", halt_o, retired_o);
    end
    drive(2'b00, 1'b0, 0, 0, 0, 0);
    tick();
    total++;
    if (halt_o !== 1'b0) begin
      bad++; $display("FAIL halt_early halt=%b want 0", halt_o);
    end
    tick();
    total++;
    if (halt_o !== 1'b1) begin
      bad++; $display("FAIL halt_rise halt=%b want 1", halt_o);
    end
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 1'b0, 32'h500, 32'h504, 32'h504, 32'h508);
      tick();
      total++;
      if (commit_o !== 2'b00 || retired_o !== 64'd4 || halt_o !== 1'b1) begin
        bad++; $display("FAIL halted_ignore_%0d commit=%b retired=%0d halt=%b want 00 4 1",
                        k, commit_o, retired_o, halt_o);
      end
    end
  endtask

  task automatic test_reset_in_halt();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (halt_o !== 1'b0 || retired_o !== 64'd0 || commit_o !== 2'b00) begin
      bad++; $display("FAIL async_reset halt=%b retired=%0d commit=%b want 0 0 00", halt_o, retired_o, commit_o);
    end
    #2;
    rst = 1'b1;
    drive(2'b01, 1'b0, 32'h600, 32'h604, 0, 0);
    tick();
    total++;
    if (commit_o !== 2'b01 || order_o[63:0] !== 64'd0 || retired_o !== 64'd1) begin
      bad++; $display("FAIL restart_order commit=%b ord0=%0d retired=%0d want 01 0 1",
                      commit_o, order_o[63:0], retired_o);
    end
  endtask

  task automatic test_random();
    logic [1:0]  v;
    logic        s;
    logic [31:0] r0, w0, r1, w1;
    int halted_cycles;
    apply_reset();
    model_reset();
    halted_cycles = 0;
    for (int c = 0; c < 600; c++) begin
      if (halted_cycles >= 3) begin
        apply_reset();
        model_reset();
        halted_cycles = 0;
      end
      v  = 2'($urandom_range(0, 3));
      s  = ($urandom_range(0, 3) == 0);
      r0 = 32'h100 + 32'(4 * $urandom_range(0, 2));
      r1 = 32'h100 + 32'(4 * $urandom_range(0, 2));
      w0 = ($urandom_range(0, 2) != 0) ? r0 : r0 + 32'd4;
      w1 = ($urandom_range(0, 2) != 0) ? r1 : r1 + 32'd4;
      drive(v, s, r0, w0, r1, w1);
      model_edge(v, s, r0, w0, r1, w1);
      tick();
      total++;
      if (commit_o !== m_commit) begin
        bad++; $display("FAIL rand_commit c=%0d got=%b want=%b", c, commit_o, m_commit);
      end
      total++;
      if (retired_o !== m_ret) begin
        bad++; $display("FAIL rand_retired c=%0d got=%0d want=%0d", c, retired_o, m_ret);
      end
      total++;
      if (halt_o !== m_halt) begin
        bad++; $display("FAIL rand_halt c=%0d got=%b want=%b", c, halt_o, m_halt);
      end
      for (int i = 0; i < 2; i++) begin
        if (m_commit[i]) begin
          total++;
          if (order_o[i*64 +: 64] !== m_ord[i]) begin
            bad++; $display("FAIL rand_order c=%0d lane=%0d got=%0d want=%0d",
                            c, i, order_o[i*64 +: 64], m_ord[i]);
          end
        end
      end
      if (m_halt) halted_cycles++;
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(2'b00, 1'b0, 0, 0, 0, 0);
    test_reset();
    test_full_width();
    test_sparse();
    test_stall();
    test_loop_switch();
    test_halt();
    test_reset_in_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
